player_powerup_ctrl: RTL
========================

Name: player_powerup_ctrl

Overview:
Parametrised successor to the fixed two-switch powerup latch in the player top. It manages N_PWR independent powerup channels (channel 0 = speedy, channel 1 = invincible by default). Each channel is a timed IDLE/ACTIVE/COOLDOWN state machine, driven by one-cycle pickup pulses from the collision logic, with sw kept as a debug override. It sits between the pickup/collision logic and player_pos / player_hitbox / player_led / player_display, replacing the player_is_* registers.

Parameters:
N_PWR, 2, number of powerup channels
TICK_DIV, 1000000, clock_100mhz cycles per timer tick (10 ms)
DUR_TICKS, 500, ACTIVE duration in ticks (5 s)
CD_TICKS, 300, COOLDOWN duration in ticks; 0 = no cooldown
TW, derived, timer width = $clog2(max(DUR_TICKS, CD_TICKS) + 1); uses 2*DUR_TICKS when PWR_STACK_EN is defined

Ports:
clock_100mhz  in  1  system clock
reset  in  1  synchronous, active-high reset
game_active  in  1  low = game not running; acts as clear
pickup  in  N_PWR  one-cycle pickup pulse per channel
sw  in  N_PWR  debug override, level
pwr_active  out  N_PWR  powerup in effect (FSM ACTIVE OR sw)
pwr_cooldown  out  N_PWR  channel in COOLDOWN
pwr_time_left  out  N_PWR*TW  packed timer per channel; channel i at [i*TW +: TW]
led_bar  out  16  thermometer of remaining ACTIVE time

Behaviour:
- Interface: one clock, clock_100mhz; reset is synchronous and active-high.
- Reset, or game_active==0, on a clock edge:
  - prescaler=0, all channels IDLE, timers=0.
  - pwr_active=0, pwr_cooldown=0, led_bar=0.
  - sw override is also suppressed while game_active==0.
- Prescaler: counts 0..TICK_DIV-1 while game_active. tick is a 1-cycle internal pulse when the count wraps from TICK_DIV-1 to 0.
- All outputs are registered. An input at edge k appears at the outputs after edge k+1.
- Per-channel FSM (states IDLE, ACTIVE, COOLDOWN):
  - IDLE: pickup -> ACTIVE, timer=DUR_TICKS.
  - ACTIVE, pickup: timer=DUR_TICKS (refresh). pickup has priority over a tick in the same cycle.
  - ACTIVE, tick with no pickup: timer-1. If timer was 1 -> COOLDOWN with timer=CD_TICKS, or -> IDLE with timer=0 when CD_TICKS==0.
  - COOLDOWN: pickup ignored. On tick timer-1; if timer was 1 -> IDLE, timer=0.
  - IDLE: timer=0 always.
- Outputs:
  - pwr_active[i] = (state==ACTIVE) | (sw[i] & game_active).
  - sw never changes FSM state or timer.
  - pwr_cooldown[i] = (state==COOLDOWN).
  - pwr_time_left holds the raw timer value in both ACTIVE and COOLDOWN.
- led_bar:
  - Source channel is the lowest-index channel in FSM ACTIVE.
  - lit = ceil(time_left*16/DUR_TICKS), clamped to 16; LEDs [lit-1:0] on.
  - No channel in FSM ACTIVE -> 0.
  - Division is by a constant, evaluated combinationally, then registered.
- Channels are fully independent. Simultaneous pickups on several channels are all accepted in the same cycle.
- Timers never underflow or wrap. Decrementing happens only when timer>=1.

Optional Feature:
PWR_STACK_EN
- Defined: a pickup in ACTIVE adds DUR_TICKS to the timer, saturating at 2*DUR_TICKS. TW widens accordingly. led_bar clamps at 16.
- Undefined: pickup in ACTIVE refreshes the timer to DUR_TICKS, as described above.

Decomposition:
- Shared package player_pkg holds:
  - state encodings PWR_IDLE=2'd0, PWR_ACTIVE=2'd1, PWR_COOLDOWN=2'd2;
  - channel index constants PWR_SPEEDY=0, PWR_INVINCIBLE=1;
  - LED_BAR_W=16.
- Sub-module powerup_channel: one FSM plus its timer, instantiated N_PWR times via generate.
- Prescaler and led_bar encoder live in the top.

Test Plan (bench params: TICK_DIV=4, DUR_TICKS=5, CD_TICKS=3, N_PWR=2):
1. Reset held 3 cycles with game_active=1, sw=2'b11 -> during reset all outputs 0. First edge after release: pwr_active=2'b11, led_bar=0.
2. pickup[0] pulse at cycle 10 -> cycle 11: pwr_active[0]=1, time_left0=5, led_bar=16'hFFFF. Timer 5->0 over 20 cycles, then pwr_cooldown[0]=1 for 12 cycles, then IDLE with all channel-0 outputs 0.
3. At time_left0=2 (led_bar=16'h007F), pulse pickup[0] on a tick cycle -> time_left0=5 (or 7 with PWR_STACK_EN; repeat pickups saturate at 10). A pickup during COOLDOWN leaves state and timer unchanged.
4. pickup[0] and pickup[1] on the same cycle; drop game_active 3 cycles later -> next cycle all outputs 0. Restore game_active -> both channels IDLE and the prescaler restarts from 0.
5. sw[1]=1 with no pickup -> pwr_active[1]=1, pwr_cooldown[1]=0, time_left1=0, led_bar=0. Then pickup[1] -> led_bar follows channel 1 only while channel 0 is not ACTIVE.
6. CD_TICKS=0 build, run a pickup to expiry -> ACTIVE goes straight to IDLE; pwr_cooldown is never asserted.

Source files
------------

// File: rtl/player_pkg.sv
// Shared definitions for the player powerup logic: channel state encoding,
// channel indices, LED bar width and the timer-range helper (honours PWR_STACK_EN).
package player_pkg;

  typedef enum logic [1:0] {
    PWR_IDLE     = 2'd0,
    PWR_ACTIVE   = 2'd1,
    PWR_COOLDOWN = 2'd2
  } pwr_state_e;

  localparam int PWR_SPEEDY     = 0;
  localparam int PWR_INVINCIBLE = 1;
  localparam int LED_BAR_W      = 16;

  // Largest value a channel timer can ever hold.
  function automatic int unsigned pwr_timer_max(input int unsigned dur,
                                                input int unsigned cd);
    int unsigned m;
`ifdef PWR_STACK_EN
    m = 2 * dur;
`else
    m = dur;
`endif
    return (cd > m) ? cd : m;
  endfunction

endpackage

// File: rtl/powerup_channel.sv
// One powerup channel: IDLE/ACTIVE/COOLDOWN FSM with its tick-driven timer.
// Optional macro PWR_STACK_EN: pickups while ACTIVE add time instead of refreshing.
module powerup_channel
  import player_pkg::*;
#(
  parameter int unsigned DUR_TICKS = 500,
  parameter int unsigned CD_TICKS  = 300,
  parameter int unsigned TW        = 9
) (
  input  logic          clk_i,
  input  logic          clr_i,
  input  logic          tick_i,
  input  logic          pickup_i,
  input  logic          sw_i,
  output logic          active_o,
  output logic          cooldown_o,
  output logic [TW-1:0] time_left_o,
  output logic          nxt_active_o,
  output logic [TW-1:0] nxt_timer_o
);

  localparam logic [TW-1:0] DUR_T = TW'(DUR_TICKS);
  localparam logic [TW-1:0] CD_T  = TW'(CD_TICKS);

  pwr_state_e    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          active_q, cooldown_q;

`ifdef PWR_STACK_EN
  localparam logic [TW:0] SAT_T = (TW+1)'(2 * DUR_TICKS);
  logic [TW:0] stacked;
  assign stacked = {1'b0, timer_q} + {1'b0, DUR_T};
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      PWR_IDLE: begin
        timer_d = '0;
        if (pickup_i) begin
          state_d = PWR_ACTIVE;
          timer_d = DUR_T;
        end
      end
      PWR_ACTIVE: begin
        if (pickup_i) begin
`ifdef PWR_STACK_EN
          timer_d = (stacked > SAT_T) ? SAT_T[TW-1:0] : stacked[TW-1:0];
`else
          timer_d = DUR_T;
`endif
        end else if (tick_i && timer_q != '0) begin
          if (timer_q == TW'(1)) begin
            state_d = (CD_TICKS == 0) ? PWR_IDLE : PWR_COOLDOWN;
            timer_d = CD_T;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
      end
      PWR_COOLDOWN: begin
        if (tick_i && timer_q != '0) begin
          if (timer_q == TW'(1)) state_d = PWR_IDLE;
          timer_d = timer_q - TW'(1);
        end
      end
      default: begin
        state_d = PWR_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      state_q    <= PWR_IDLE;
      timer_q    <= '0;
      active_q   <= 1'b0;
      cooldown_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      active_q   <= (state_d == PWR_ACTIVE) | sw_i;
      cooldown_q <= (state_d == PWR_COOLDOWN);
    end
  end

  assign active_o     = active_q;
  assign cooldown_o   = cooldown_q;
  assign time_left_o  = timer_q;
  // Next-state view lets the top register led_bar in the same cycle as the timers.
  assign nxt_active_o = (state_d == PWR_ACTIVE);
  assign nxt_timer_o  = timer_d;

endmodule

// File: rtl/player_powerup_ctrl.sv
// N_PWR timed powerup channels with a shared tick prescaler and remaining-time LED bar.
// Optional macro PWR_STACK_EN: stacking pickups, timer saturates at 2*DUR_TICKS.
module player_powerup_ctrl
  import player_pkg::*;
#(
  parameter  int unsigned N_PWR     = 2,
  parameter  int unsigned TICK_DIV  = 1000000,
  parameter  int unsigned DUR_TICKS = 500,
  parameter  int unsigned CD_TICKS  = 300,
  localparam int unsigned TW        = $clog2(pwr_timer_max(DUR_TICKS, CD_TICKS) + 1)
) (
  input  logic                  clock_100mhz,
  input  logic                  reset,
  input  logic                  game_active,
  input  logic [N_PWR-1:0]      pickup,
  input  logic [N_PWR-1:0]      sw,
  output logic [N_PWR-1:0]      pwr_active,
  output logic [N_PWR-1:0]      pwr_cooldown,
  output logic [N_PWR*TW-1:0]   pwr_time_left,
  output logic [LED_BAR_W-1:0]  led_bar
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned LW = TW + 5;

  logic          clr;
  logic          tick;
  logic [PW-1:0] presc_q, presc_d;

  // A stopped game behaves exactly like reset.
  assign clr     = reset | ~game_active;
  assign tick    = (presc_q == PW'(TICK_DIV - 1));
  assign presc_d = tick ? '0 : presc_q + PW'(1);

  always_ff @(posedge clock_100mhz) begin
    if (clr) presc_q <= '0;
    else     presc_q <= presc_d;
  end

  logic [N_PWR-1:0] nxt_active;
  logic [TW-1:0]    nxt_timer [N_PWR];

  for (genvar g = 0; g < N_PWR; g++) begin : g_ch
    powerup_channel #(
      .DUR_TICKS (DUR_TICKS),
      .CD_TICKS  (CD_TICKS),
      .TW        (TW)
    ) u_ch (
      .clk_i        (clock_100mhz),
      .clr_i        (clr),
      .tick_i       (tick),
      .pickup_i     (pickup[g]),
      .sw_i         (sw[g] & game_active),
      .active_o     (pwr_active[g]),
      .cooldown_o   (pwr_cooldown[g]),
      .time_left_o  (pwr_time_left[g*TW +: TW]),
      .nxt_active_o (nxt_active[g]),
      .nxt_timer_o  (nxt_timer[g])
    );
  end

  logic                 src_valid;
  logic [TW-1:0]        src_timer;
  logic [LW-1:0]        lit_raw;
  logic [4:0]           lit;
  logic [LED_BAR_W-1:0] led_d, led_q;

  always_comb begin
    src_valid = 1'b0;
    src_timer = '0;
    // Walk downward so the lowest-index ACTIVE channel wins.
    for (int i = int'(N_PWR) - 1; i >= 0; i--) begin
      if (nxt_active[i]) begin
        src_valid = 1'b1;
        src_timer = nxt_timer[i];
      end
    end
    lit_raw = (({5'b0, src_timer} << 4) + LW'(DUR_TICKS - 1)) / LW'(DUR_TICKS);
    lit     = (lit_raw > LW'(LED_BAR_W)) ? 5'(LED_BAR_W) : lit_raw[4:0];
    led_d   = '0;
    for (int j = 0; j < LED_BAR_W; j++) begin
      led_d[j] = src_valid && (5'(j) < lit);
    end
  end

  always_ff @(posedge clock_100mhz) begin
    if (clr) led_q <= '0;
    else     led_q <= led_d;
  end

  assign led_bar = led_q;

endmodule
